lc2k_fetch_unit: RTL
====================

# lc2k_fetch_unit

Instruction fetch and field-decode stage for the LC2K multicycle CPU. Owns the PC, fetches one 32-bit instruction word per instruction over a req/ack handshake to instruction memory, holds it in an instruction register, and presents the decoded fields to the downstream stages. Its `opcode` output feeds the control ROM; the remaining fields go to the register file and ALU. The block advances only when the downstream datapath signals completion, taking the next PC from a branch/jalr redirect when one is supplied.

## Interface
- `ADDR_W`, 16, PC / instruction-memory address width; PC wraps modulo 2^ADDR_W
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `imem_req`  out  1  fetch request, registered
- `imem_addr`  out  ADDR_W  fetch address (= PC), stable while `imem_req`=1
- `imem_ack`  in  1  memory response; `imem_rdata` valid in the same cycle
- `imem_rdata`  in  32  instruction word
- `advance`  in  1  downstream done with current instruction
- `redirect_valid`  in  1  next PC comes from `redirect_pc` (taken beq / jalr)
- `redirect_pc`  in  ADDR_W  redirect target
- `halt`  in  1  current instruction is halt (control ROM halt flag)
- `instr_valid`  out  1  decoded fields are valid
- `opcode`  out  3  IR[24:22]
- `reg_a`  out  3  IR[21:19]
- `reg_b`  out  3  IR[18:16]
- `dest`  out  3  IR[2:0]
- `offset_ext`  out  32  IR[15:0] sign-extended
- `pc`  out  ADDR_W  address of the current instruction
- `pc_plus1`  out  ADDR_W  `pc`+1, wrapping
- `halted`  out  1  fetch permanently stopped

## Operation
- States: IDLE, FETCH, HOLD, HALTED.
- IDLE: entered on reset; unconditionally goes to FETCH on the next edge.
- FETCH: `imem_req`=1, `imem_addr`=PC. On `imem_ack`: IR<=`imem_rdata`, go to HOLD.
- HOLD: `instr_valid`=1, fields decoded from IR. Without `advance`, IR and PC hold. On `advance`:
  - `halt`=1: go to HALTED. Halt takes priority over redirect.
  - else `redirect_valid`=1: PC<=`redirect_pc`, go to FETCH.
  - else: PC<=PC+1 (wrapping), go to FETCH.
- HALTED: `halted`=1, `imem_req`=0, `instr_valid`=0. Only reset exits.
- Ignored inputs: `imem_ack` outside FETCH; `advance`, `halt` and `redirect_*` outside HOLD or without `advance`.
- Reset values: state=IDLE, PC=0, IR=0, `imem_req`=0, `instr_valid`=0, `halted`=0. Fields decode IR=0: opcode 000, all zero.

## Timing
- `imem_req`, `instr_valid` and `halted` come straight from registers, with no combinational path from inputs.
- First request: `imem_req` rises on the second rising edge after reset deassertion (one IDLE cycle).
- Ack may arrive in the first cycle `imem_req` is high (0-wait). `instr_valid` rises the edge after the ack cycle, so fetch latency = ack wait + 1.
- `imem_req` falls on the same edge `instr_valid` rises. Back-to-back: `advance` at edge N gives `imem_req`=1 in cycle N+1 with the new address.
- Reset mid-fetch aborts immediately. A late ack arriving after reset, while in IDLE, is ignored.

## Structure
- Shared package `lc2k_pkg`:
  - opcode constants ADD=000, NOR=001, LW=010, SW=011, BEQ=100, JALR=101, HALT=110, NOOP=111
  - field bit positions
  - fetch state enum
- Sub-module `lc2k_field_decode`: combinational IR to opcode/reg_a/reg_b/dest/offset_ext. The control ROM bench reuses it.

## Test plan
- Reset: hold `reset` 3 cycles, release. All outputs are at reset values during reset; `imem_req`=1 with `imem_addr`=0 in the second cycle after release.
- 0-wait fetch of 0x000A0003: `instr_valid` rises one cycle after the ack, with opcode=0, reg_a=1, reg_b=2, dest=3. A 3-cycle ack delay gives the same decode 4 cycles after req.
- Fetch 0x0081FFFF (lw 0 1 -1): opcode=010, reg_b=1, offset_ext=0xFFFFFFFF. `advance` with no redirect gives next `imem_addr`=`pc`+1.
- In HOLD at pc=5, `advance`+`redirect_valid` with `redirect_pc`=0x20: next `imem_addr`=0x20. Redirect without `advance` has no effect.
- Fetch 0x01800000 (halt), then `advance`+`halt`+`redirect_valid`: `halted`=1, and there is no `imem_req` for 20 cycles despite spurious acks.
- ADDR_W=4, pc=15, `advance`: next `imem_addr`=0 and `pc_plus1` at pc 15 = 0. Separately, assert reset mid-FETCH then ack: the ack is ignored and the restart is at address 0.

Source files
------------

// File: rtl/lc2k_pkg.sv
// Shared LC2K definitions: opcode encodings, instruction field positions and the
// fetch-stage state encoding.
package lc2k_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_NOR  = 3'b001;
  localparam logic [2:0] OP_LW   = 3'b010;
  localparam logic [2:0] OP_SW   = 3'b011;
  localparam logic [2:0] OP_BEQ  = 3'b100;
  localparam logic [2:0] OP_JALR = 3'b101;
  localparam logic [2:0] OP_HALT = 3'b110;
  localparam logic [2:0] OP_NOOP = 3'b111;

  localparam int FIELD_W    = 3;
  localparam int OPCODE_LSB = 22;
  localparam int REG_A_LSB  = 19;
  localparam int REG_B_LSB  = 16;
  localparam int DEST_LSB   = 0;
  localparam int OFFSET_LSB = 0;
  localparam int OFFSET_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HOLD   = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_e;

  function automatic logic [31:0] sext_offset(input logic [OFFSET_W-1:0] off);
    return {{(32-OFFSET_W){off[OFFSET_W-1]}}, off};
  endfunction

endpackage

// File: rtl/lc2k_field_decode.sv
// Combinational split of an LC2K instruction word into its register/opcode
// fields and a sign-extended offset.
module lc2k_field_decode
  import lc2k_pkg::*;
(
  input  logic [31:0]        i_ir,
  output logic [FIELD_W-1:0] o_opcode,
  output logic [FIELD_W-1:0] o_reg_a,
  output logic [FIELD_W-1:0] o_reg_b,
  output logic [FIELD_W-1:0] o_dest,
  output logic [31:0]        o_offset_ext
);

  // Bits 31:25 carry no meaning in LC2K.
  logic w_unused_hi;
  assign w_unused_hi = ^i_ir[31:25];

  assign o_opcode     = i_ir[OPCODE_LSB +: FIELD_W];
  assign o_reg_a      = i_ir[REG_A_LSB  +: FIELD_W];
  assign o_reg_b      = i_ir[REG_B_LSB  +: FIELD_W];
  assign o_dest       = i_ir[DEST_LSB   +: FIELD_W];
  assign o_offset_ext = sext_offset(i_ir[OFFSET_LSB +: OFFSET_W]);

endmodule

// File: rtl/lc2k_fetch_unit.sv
// LC2K fetch stage: owns the PC, fetches over a req/ack handshake, holds the
// word in IR and presents decoded fields until downstream advances.
module lc2k_fetch_unit
  import lc2k_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              advance,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              instr_valid,
  output logic [2:0]        opcode,
  output logic [2:0]        reg_a,
  output logic [2:0]        reg_b,
  output logic [2:0]        dest,
  output logic [31:0]       offset_ext,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus1,
  output logic              halted
);

  fetch_state_e      r_state;
  fetch_state_e      w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] w_pc_plus1;
  logic [31:0]       r_ir;
  logic              w_ir_load;
  logic              r_imem_req;
  logic              r_instr_valid;
  logic              r_halted;

  assign w_pc_plus1 = r_pc + ADDR_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_load   = 1'b0;
    case (r_state)
      ST_IDLE:  w_state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack) begin
          w_ir_load   = 1'b1;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Halt outranks a redirect presented in the same cycle.
        if (advance) begin
          if (halt) begin
            w_state_nxt = ST_HALTED;
          end else begin
            w_state_nxt = ST_FETCH;
            w_pc_nxt    = redirect_valid ? redirect_pc : w_pc_plus1;
          end
        end
      end
      ST_HALTED: w_state_nxt = ST_HALTED;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they carry no
  // combinational path from the inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_pc          <= '0;
      r_ir          <= '0;
      r_imem_req    <= 1'b0;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      if (w_ir_load) r_ir <= imem_rdata;
      r_imem_req    <= (w_state_nxt == ST_FETCH);
      r_instr_valid <= (w_state_nxt == ST_HOLD);
      r_halted      <= (w_state_nxt == ST_HALTED);
    end
  end

  lc2k_field_decode u_decode (
    .i_ir         (r_ir),
    .o_opcode     (opcode),
    .o_reg_a      (reg_a),
    .o_reg_b      (reg_b),
    .o_dest       (dest),
    .o_offset_ext (offset_ext)
  );

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_pc;
  assign instr_valid = r_instr_valid;
  assign halted      = r_halted;
  assign pc          = r_pc;
  assign pc_plus1    = w_pc_plus1;

endmodule
